mem_stage_stack_ctrl: RTL and testbench
=======================================

Name: mem_stage_stack_ctrl

Overview:
Parametrised successor of the single-cycle memory pipeline stage. It owns the data memory and a hardware stack pointer, and executes load/store, single-word push/pop, and multi-word CALL/RET/INT/RTI transfers of the PC (plus flags for INT/RTI). Multi-word transfers stall upstream. Results and write-back control are registered into a MEM/WB buffer. It sits between the execute stage and the write-back stage.

Parameters:
DATA_W, 16, memory word and register data width
ADDR_W, 11, memory address width; DEPTH = 2**ADDR_W words
PC_W, 32, program counter width; must be a multiple of DATA_W; PC_WORDS = PC_W/DATA_W
FLAG_W, 3, flag vector width (FLAG_W <= DATA_W)
PASS_W, 4, width of the opaque write-back control bundle carried through

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  op fields valid this cycle
op  in  4  mem_op_t operation code
addr  in  ADDR_W  LOAD/STORE address
wdata  in  DATA_W  STORE/PUSH data
pc  in  PC_W  PC to save (CALL/INT)
flags  in  FLAG_W  flags to save (INT)
pass_in  in  PASS_W  write-back control bundle
stall  out  1  hold upstream; inputs must stay stable while high
out_valid  out  1  MEM/WB buffer holds a completed op
data_r  out  DATA_W  LOAD/POP result
pc_out  out  PC_W  restored PC (RET/RTI)
pc_load  out  1  pc_out valid, one cycle
flags_out  out  FLAG_W  restored flags (RTI)
flags_load  out  1  flags_out valid, one cycle
pass_out  out  PASS_W  registered pass_in
exc_ovf  out  1  stack overflow, one-cycle pulse
exc_unf  out  1  stack underflow, one-cycle pulse
sp_dbg  out  ADDR_W  current stack pointer

Behaviour:
- Reset (async, high): SP = DEPTH-1; occupancy = 0; FSM = IDLE; word counter = 0. All registered outputs go to 0. Memory contents are not reset.
- Memory: synchronous write, combinational read. Read data and status are captured into the output buffer. Latency is one clock after the final word of an op.
- Stack is full-descending. PUSH writes mem[SP], then SP-1 and occ+1. POP reads mem[SP+1], then SP+1 and occ-1. SP arithmetic wraps mod DEPTH.
- LOAD: data_r <= mem[addr]. STORE: mem[addr] <= wdata. NOP produces out_valid=1 with only pass_out meaningful.
- CALL: pushes PC_WORDS words, most-significant first.
- INT: pushes PC_WORDS words, most-significant first, then one flags word (zero-extended).
- RET: pops PC_WORDS words, least-significant first, reassembles pc_out, and pulses pc_load.
- RTI: pops the flags word first, then the PC words as RET; pulses flags_load and pc_load together.
- FSM has states IDLE and BURST, with counter k = words remaining.
  - IDLE: a multi-word op of N words with N>1 does word 1 this cycle, asserts stall, and moves to BURST with k = N-1.
  - BURST: does one word per cycle with stall=1 while k>1. The final word has stall=0, and the FSM returns to IDLE.
  - CALL with PC_WORDS=2: stall is high for exactly 1 cycle.
- While stall=1, out_valid=0, which inserts a bubble. pass_in is captured with the final word.
- Overflow/underflow checks are made in IDLE against the whole op (occ+N > DEPTH, or occ < N).
  - On failure: no memory write, SP unchanged, no stall.
  - exc_ovf or exc_unf pulses with out_valid=1; pc_load and flags_load stay 0.
- in_valid=0 in IDLE: out_valid <= 0, and no state change.
- Reset mid-BURST: the op is abandoned immediately. Partially pushed words stay in memory, but SP and occupancy return to reset values.
- Undefined op codes behave as NOP.

Decomposition:
- Package mem_stage_pkg holds:
  - mem_op_t enum: NOP=0, LOAD, STORE, PUSH, POP, CALL, RET, INT, RTI
  - a function words_for(op) returning the word count
  - the shared parameter defaults
- One natural sub-module, stack_pointer_unit: holds SP and occupancy, takes push/pop/n requests, and produces ovf/unf flags.
- The data memory array is inline. The output buffer reuses the team's existing var_reg.

Test Plan:
1. Reset, then STORE addr=0x010 wdata=0xBEEF, then LOAD 0x010 -> next cycle data_r=0xBEEF, out_valid=1, sp_dbg=0x7FF.
2. PUSH 0x1111, then PUSH 0x2222, then POP, then POP -> data_r=0x2222, then 0x1111; sp_dbg=0x7FD after the pushes, 0x7FF after the pops.
3. CALL pc=0x0001_2345 -> stall=1 for one cycle; mem[0x7FF]=0x0001, mem[0x7FE]=0x2345. A following RET -> pc_out=0x0001_2345 with pc_load pulse, and out_valid=0 during the stall cycle.
4. INT pc=0x0000_0040 flags=3'b101, then RTI -> stall high 2 cycles each way; flags_out=3'b101 and pc_out=0x40 in the same cycle.
5. POP on an empty stack -> exc_unf=1 for one cycle, sp_dbg stays 0x7FF, no stall. Separately, fill to occ=2047 and issue CALL -> exc_ovf=1 and no memory write.
6. Assert reset during the BURST cycle of a CALL -> stall=0, sp_dbg=0x7FF and all outputs 0 immediately. The next RET returns exc_unf.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types, defaults and word-count helper for the memory stage with hardware stack.
package mem_stage_pkg;

    localparam int unsigned MS_DATA_W = 16;
    localparam int unsigned MS_ADDR_W = 11;
    localparam int unsigned MS_PC_W   = 32;
    localparam int unsigned MS_FLAG_W = 3;
    localparam int unsigned MS_PASS_W = 4;

    typedef enum logic [3:0] {
        NOP   = 4'd0,
        LOAD  = 4'd1,
        STORE = 4'd2,
        PUSH  = 4'd3,
        POP   = 4'd4,
        CALL  = 4'd5,
        RET   = 4'd6,
        INT   = 4'd7,
        RTI   = 4'd8
    } mem_op_t;

    // Number of stack words moved by an op; INT/RTI carry one extra flags word.
    function automatic int unsigned words_for(input mem_op_t op, input int unsigned pc_words);
        case (op)
            PUSH, POP: return 1;
            CALL, RET: return pc_words;
            INT, RTI:  return pc_words + 1;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_stack_ctrl_sp.sv
// Stack pointer and occupancy tracker with whole-op overflow/underflow detection.
module stack_pointer_unit
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = MS_ADDR_W,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_step,
    input  logic              pop_step,
    input  logic [CNT_W-1:0]  n_words,
    output logic [ADDR_W-1:0] sp,
    output logic              ovf_c,
    output logic              unf_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned OCC_W = ADDR_W + 1;
    localparam int unsigned SUM_W = ADDR_W + 2;

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [SUM_W-1:0]  need;

    always_comb begin
        sp_d  = sp_q;
        occ_d = occ_q;
        if (push_step) begin
            sp_d  = sp_q - ADDR_W'(1);
            occ_d = occ_q + OCC_W'(1);
        end else if (pop_step) begin
            sp_d  = sp_q + ADDR_W'(1);
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q  <= ADDR_W'(DEPTH - 1);
            occ_q <= '0;
        end else begin
            sp_q  <= sp_d;
            occ_q <= occ_d;
        end
    end

    assign need  = SUM_W'(occ_q) + SUM_W'(n_words);
    assign ovf_c = need > SUM_W'(DEPTH);
    assign unf_c = occ_q < OCC_W'(n_words);
    assign sp    = sp_q;

endmodule

// File: rtl/mem_stage_stack_ctrl.sv
// Memory pipeline stage: data memory, hardware stack and multi-word CALL/RET/INT/RTI sequencing.
module mem_stage_stack_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = MS_DATA_W,
    parameter int unsigned ADDR_W = MS_ADDR_W,
    parameter int unsigned PC_W   = MS_PC_W,
    parameter int unsigned FLAG_W = MS_FLAG_W,
    parameter int unsigned PASS_W = MS_PASS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PC_W-1:0]   pc,
    input  logic [FLAG_W-1:0] flags,
    input  logic [PASS_W-1:0] pass_in,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_r,
    output logic [PC_W-1:0]   pc_out,
    output logic              pc_load,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_load,
    output logic [PASS_W-1:0] pass_out,
    output logic              exc_ovf,
    output logic              exc_unf,
    output logic [ADDR_W-1:0] sp_dbg
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam int unsigned PC_WORDS = PC_W / DATA_W;
    localparam int unsigned CNT_W    = $clog2(PC_WORDS + 2);
    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  BURST    = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  k_q, k_d;
    logic [PC_W-1:0]   pc_acc_q, pc_acc_d;
    logic [FLAG_W-1:0] flg_acc_q, flg_acc_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data_r_q, data_r_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;
    logic              pc_load_q, pc_load_d;
    logic [FLAG_W-1:0] flags_out_q, flags_out_d;
    logic              flags_load_q, flags_load_d;
    logic [PASS_W-1:0] pass_out_q, pass_out_d;
    logic              exc_ovf_q, exc_ovf_d;
    logic              exc_unf_q, exc_unf_d;

    mem_op_t           op_e;
    logic              is_push, is_pop;
    logic [CNT_W-1:0]  n_words, widx;
    logic              stall_c, word_go, last, finish;
    logic              push_step, pop_step, ovf_c, unf_c;
    logic [ADDR_W-1:0] sp;
    int                pw;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    assign op_e    = mem_op_t'(op);
    assign is_push = (op_e == PUSH) || (op_e == CALL) || (op_e == INT);
    assign is_pop  = (op_e == POP)  || (op_e == RET)  || (op_e == RTI);
    assign n_words = CNT_W'(words_for(op_e, PC_WORDS));

    stack_pointer_unit #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_sp (
        .clk       (clk),
        .reset     (reset),
        .push_step (push_step),
        .pop_step  (pop_step),
        .n_words   (n_words),
        .sp        (sp),
        .ovf_c     (ovf_c),
        .unf_c     (unf_c)
    );

    // Pops always read just above SP; everything else reads the explicit address.
    assign mem_raddr = is_pop ? (sp + ADDR_W'(1)) : addr;
    assign mem_rdata = mem[mem_raddr];

    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        pc_acc_d     = pc_acc_q;
        flg_acc_d    = flg_acc_q;
        out_valid_d  = 1'b0;
        data_r_d     = data_r_q;
        pc_out_d     = pc_out_q;
        pc_load_d    = 1'b0;
        flags_out_d  = flags_out_q;
        flags_load_d = 1'b0;
        pass_out_d   = pass_out_q;
        exc_ovf_d    = 1'b0;
        exc_unf_d    = 1'b0;
        stall_c      = 1'b0;
        word_go      = 1'b0;
        last         = 1'b0;
        finish       = 1'b0;
        push_step    = 1'b0;
        pop_step     = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = sp;
        mem_wdata    = wdata;
        widx         = '0;
        pw           = 0;

        if (state_q == IDLE) begin
            if (in_valid) begin
                if (is_push && ovf_c) begin
                    exc_ovf_d = 1'b1;
                    finish    = 1'b1;
                end else if (is_pop && unf_c) begin
                    exc_unf_d = 1'b1;
                    finish    = 1'b1;
                end else if (is_push || is_pop) begin
                    word_go = 1'b1;
                    if (n_words > CNT_W'(1)) begin
                        state_d = BURST;
                        k_d     = n_words - CNT_W'(1);
                        stall_c = 1'b1;
                    end else begin
                        last = 1'b1;
                    end
                end else begin
                    finish = 1'b1;
                    if (op_e == LOAD) data_r_d = mem_rdata;
                    if (op_e == STORE) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr;
                    end
                end
            end
        end else begin
            word_go = 1'b1;
            widx    = n_words - k_q;
            if (k_q > CNT_W'(1)) begin
                k_d     = k_q - CNT_W'(1);
                stall_c = 1'b1;
            end else begin
                last    = 1'b1;
                state_d = IDLE;
                k_d     = '0;
            end
        end

        // Pushes go PC most-significant word first, then flags; pops mirror that order.
        if (word_go && is_push) begin
            push_step = 1'b1;
            mem_we    = 1'b1;
            mem_waddr = sp;
            pw        = int'(PC_WORDS) - 1 - int'(widx);
            if (op_e == PUSH)  mem_wdata = wdata;
            else if (pw >= 0)  mem_wdata = DATA_W'(pc >> (pw * int'(DATA_W)));
            else               mem_wdata = DATA_W'(flags);
        end
        if (word_go && is_pop) begin
            pop_step = 1'b1;
            pw       = (op_e == RTI) ? int'(widx) - 1 : int'(widx);
            if (op_e == RTI && widx == '0) flg_acc_d = mem_rdata[FLAG_W-1:0];
            else if (op_e != POP)          pc_acc_d[pw*int'(DATA_W) +: DATA_W] = mem_rdata;
        end

        if (last) begin
            finish = 1'b1;
            if (op_e == POP) data_r_d = mem_rdata;
            if (op_e == RET || op_e == RTI) begin
                pc_out_d  = pc_acc_d;
                pc_load_d = 1'b1;
            end
            if (op_e == RTI) begin
                flags_out_d  = flg_acc_d;
                flags_load_d = 1'b1;
            end
        end
        if (finish) begin
            out_valid_d = 1'b1;
            pass_out_d  = pass_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            pc_acc_q     <= '0;
            flg_acc_q    <= '0;
            out_valid_q  <= 1'b0;
            data_r_q     <= '0;
            pc_out_q     <= '0;
            pc_load_q    <= 1'b0;
            flags_out_q  <= '0;
            flags_load_q <= 1'b0;
            pass_out_q   <= '0;
            exc_ovf_q    <= 1'b0;
            exc_unf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            pc_acc_q     <= pc_acc_d;
            flg_acc_q    <= flg_acc_d;
            out_valid_q  <= out_valid_d;
            data_r_q     <= data_r_d;
            pc_out_q     <= pc_out_d;
            pc_load_q    <= pc_load_d;
            flags_out_q  <= flags_out_d;
            flags_load_q <= flags_load_d;
            pass_out_q   <= pass_out_d;
            exc_ovf_q    <= exc_ovf_d;
            exc_unf_q    <= exc_unf_d;
        end
    end

    assign stall      = stall_c && !reset;
    assign out_valid  = out_valid_q;
    assign data_r     = data_r_q;
    assign pc_out     = pc_out_q;
    assign pc_load    = pc_load_q;
    assign flags_out  = flags_out_q;
    assign flags_load = flags_load_q;
    assign pass_out   = pass_out_q;
    assign exc_ovf    = exc_ovf_q;
    assign exc_unf    = exc_unf_q;
    assign sp_dbg     = sp;

endmodule

// File: tb/tb_mem_stage_stack_ctrl.sv
// Randomised self-checking bench for mem_stage_stack_ctrl against a word-level stack/memory model.
module tb_mem_stage_stack_ctrl;

    localparam logic [3:0] OP_NOP = 4'd0, OP_LOAD = 4'd1, OP_STORE = 4'd2, OP_PUSH = 4'd3,
                           OP_POP = 4'd4, OP_CALL = 4'd5, OP_RET = 4'd6, OP_INT = 4'd7,
                           OP_RTI = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  op = '0;
    logic [10:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [31:0] pc = '0;
    logic [2:0]  flags = '0;
    logic [3:0]  pass_in = '0;
    logic        stall, out_valid, pc_load, flags_load, exc_ovf, exc_unf;
    logic [15:0] data_r;
    logic [31:0] pc_out;
    logic [2:0]  flags_out;
    logic [3:0]  pass_out;
    logic [10:0] sp_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: flat memory plus a full-descending stack pointer.
    logic [15:0] m_mem [2048];
    bit          m_known [2048];
    int          m_sp = 2047;
    int          m_occ = 0;
    bit          e_ovf, e_unf, e_pcl, e_fll, e_chk_data;
    logic [31:0] e_pc;
    logic [2:0]  e_fl;
    logic [15:0] e_data;
    int          e_stall;

    mem_stage_stack_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .addr(addr),
        .wdata(wdata), .pc(pc), .flags(flags), .pass_in(pass_in), .stall(stall),
        .out_valid(out_valid), .data_r(data_r), .pc_out(pc_out), .pc_load(pc_load),
        .flags_out(flags_out), .flags_load(flags_load), .pass_out(pass_out),
        .exc_ovf(exc_ovf), .exc_unf(exc_unf), .sp_dbg(sp_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_push(input logic [15:0] w);
        m_mem[m_sp]   = w;
        m_known[m_sp] = 1'b1;
        m_sp          = (m_sp - 1) & 2047;
        m_occ++;
    endfunction

    function automatic logic [15:0] m_pop();
        m_sp = (m_sp + 1) & 2047;
        m_occ--;
        return m_mem[m_sp];
    endfunction

    function automatic void model_op(input logic [3:0] o, input logic [10:0] a,
                                     input logic [15:0] wd, input logic [31:0] p,
                                     input logic [2:0] f);
        int n;
        logic [15:0] w0, w1, w2;
        e_ovf = 0; e_unf = 0; e_pcl = 0; e_fll = 0; e_chk_data = 0; e_stall = 0;
        case (o)
            OP_PUSH, OP_POP: n = 1;
            OP_CALL, OP_RET: n = 2;
            OP_INT, OP_RTI:  n = 3;
            default:         n = 0;
        endcase
        if (o == OP_PUSH || o == OP_CALL || o == OP_INT) begin
            if (m_occ + n > 2048) e_ovf = 1;
            else begin
                e_stall = n - 1;
                if (o == OP_PUSH) m_push(wd);
                else begin
                    m_push(p[31:16]);
                    m_push(p[15:0]);
                    if (o == OP_INT) m_push({13'd0, f});
                end
            end
        end else if (o == OP_POP || o == OP_RET || o == OP_RTI) begin
            if (m_occ < n) e_unf = 1;
            else begin
                e_stall = n - 1;
                w0 = m_pop();
                if (o == OP_POP) begin
                    e_data = w0; e_chk_data = 1;
                end else if (o == OP_RET) begin
                    w1 = m_pop();
                    e_pc = {w1, w0}; e_pcl = 1;
                end else begin
                    w1 = m_pop();
                    w2 = m_pop();
                    e_fl = w0[2:0]; e_fll = 1;
                    e_pc = {w2, w1}; e_pcl = 1;
                end
            end
        end else if (o == OP_LOAD) begin
            e_data = m_mem[a]; e_chk_data = m_known[a];
        end else if (o == OP_STORE) begin
            m_mem[a] = wd; m_known[a] = 1'b1;
        end
    endfunction

    // Called just after a rising edge; returns just after the edge that completes the op.
    task automatic run_op(input logic [3:0] o, input logic [10:0] a, input logic [15:0] wd,
                          input logic [31:0] p, input logic [2:0] f, input logic [3:0] ps);
        int sc;
        model_op(o, a, wd, p, f);
        in_valid = 1'b1; op = o; addr = a; wdata = wd; pc = p; flags = f; pass_in = ps;
        #1;
        sc = 0;
        while (stall === 1'b1 && sc < 8) begin
            @(posedge clk); #1;
            sc++;
            check("bubble_out_valid", out_valid, 0);
        end
        check("stall_cycles", sc, e_stall);
        @(posedge clk); #1;
        check("out_valid", out_valid, 1);
        check("pass_out", pass_out, ps);
        check("exc_ovf", exc_ovf, e_ovf);
        check("exc_unf", exc_unf, e_unf);
        check("pc_load", pc_load, e_pcl);
        check("flags_load", flags_load, e_fll);
        check("sp_dbg", sp_dbg, m_sp);
        if (e_chk_data) check("data_r", data_r, e_data);
        if (e_pcl) check("pc_out", pc_out, e_pc);
        if (e_fll) check("flags_out", flags_out, e_fl);
        in_valid = 1'b0; op = OP_NOP;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_out_valid", out_valid, 0);
        check("idle_pulses", {pc_load, flags_load, exc_ovf, exc_unf}, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("rst_outs", {stall, out_valid, pc_load, flags_load, exc_ovf, exc_unf}, 0);
        check("rst_data", {data_r, pass_out, flags_out}, 0);
        check("rst_pc", pc_out, 0);
        check("rst_sp", sp_dbg, 11'h7FF);
        m_sp = 2047; m_occ = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] ro;
        @(posedge clk); #1;
        apply_reset();

        // 1: store/load
        run_op(OP_STORE, 11'h010, 16'hBEEF, 0, 0, 4'h1);
        run_op(OP_LOAD, 11'h010, 0, 0, 0, 4'h2);
        check("t1_data", data_r, 16'hBEEF);
        check("t1_sp", sp_dbg, 11'h7FF);

        // 2: push/pop ordering
        run_op(OP_PUSH, 0, 16'h1111, 0, 0, 4'h3);
        run_op(OP_PUSH, 0, 16'h2222, 0, 0, 4'h4);
        check("t2_sp_pushed", sp_dbg, 11'h7FD);
        run_op(OP_POP, 0, 0, 0, 0, 4'h5);
        check("t2_pop1", data_r, 16'h2222);
        run_op(OP_POP, 0, 0, 0, 0, 4'h6);
        check("t2_pop2", data_r, 16'h1111);
        check("t2_sp_popped", sp_dbg, 11'h7FF);

        // 3: call/ret
        run_op(OP_CALL, 0, 0, 32'h0001_2345, 0, 4'h7);
        run_op(OP_LOAD, 11'h7FF, 0, 0, 0, 4'h8);
        check("t3_mem_hi", data_r, 16'h0001);
        run_op(OP_LOAD, 11'h7FE, 0, 0, 0, 4'h9);
        check("t3_mem_lo", data_r, 16'h2345);
        run_op(OP_RET, 0, 0, 0, 0, 4'hA);
        check("t3_pc", pc_out, 32'h0001_2345);
        idle_cycle();

        // 4: int/rti
        run_op(OP_INT, 0, 0, 32'h0000_0040, 3'b101, 4'hB);
        run_op(OP_RTI, 0, 0, 0, 0, 4'hC);
        check("t4_flags", flags_out, 3'b101);
        check("t4_pc", pc_out, 32'h40);
        idle_cycle();

        // 5a: underflow
        run_op(OP_POP, 0, 0, 0, 0, 4'hD);
        check("t5_unf", exc_unf, 1);
        check("t5_sp", sp_dbg, 11'h7FF);
        idle_cycle();

        // Randomised traffic over a small initialised data window and the stack.
        for (int i = 0; i < 64; i++) run_op(OP_STORE, 11'(i), 16'($urandom), 0, 0, 4'($urandom));
        for (int i = 0; i < 500; i++) begin
            ro = 4'($urandom_range(0, 10));
            run_op(ro, 11'($urandom_range(0, 63)), 16'($urandom), $urandom,
                   3'($urandom), 4'($urandom));
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        // 5b: overflow at occ=2047
        apply_reset();
        for (int i = 0; i < 2047; i++) run_op(OP_PUSH, 0, 16'(i + 16'h100), 0, 0, 4'h1);
        check("t5_fill_sp", sp_dbg, 11'h000);
        run_op(OP_LOAD, 11'h000, 0, 0, 0, 4'h2);
        run_op(OP_CALL, 0, 0, 32'hDEAD_BEEF, 0, 4'h3);
        check("t5_ovf", exc_ovf, 1);
        run_op(OP_LOAD, 11'h000, 0, 0, 0, 4'h4);
        run_op(OP_POP, 0, 0, 0, 0, 4'h5);
        check("t5_top", data_r, 16'd2046 + 16'h100);

        // 6: reset in the middle of a CALL burst
        apply_reset();
        in_valid = 1'b1; op = OP_CALL; pc = 32'hCAFE_F00D; pass_in = 4'hF;
        #1;
        check("t6_stall_idle", stall, 1);
        @(posedge clk); #1;
        check("t6_stall_burst", stall, 0);
        reset = 1'b1; in_valid = 1'b0;
        #1;
        check("t6_stall", stall, 0);
        check("t6_sp", sp_dbg, 11'h7FF);
        check("t6_outs", {out_valid, pc_load, flags_load, exc_ovf, exc_unf, pass_out}, 0);
        m_mem[2047] = 16'hCAFE; m_known[2047] = 1'b1;
        m_sp = 2047; m_occ = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        run_op(OP_RET, 0, 0, 0, 0, 4'h6);
        check("t6_unf", exc_unf, 1);
        run_op(OP_LOAD, 11'h7FF, 0, 0, 0, 4'h7);
        check("t6_partial", data_r, 16'hCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
